lru_req_port: RTL and testbench
===============================

LRU_REQ_PORT -- requirements
Module: lru_req_port

Interface
REQ-001 Parameter NUM_REQ, default 10: number of requester channels; each channel has one req/gnt bit pair on the arbiter interface.
REQ-002 Parameter DATA_W, default 8: payload width per transaction.
REQ-003 Parameter DEPTH, default 4: per-channel FIFO entries; SHALL be a power of 2 and at least 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_b  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  NUM_REQ  per-channel transaction offered.
REQ-007 in_ready  output  NUM_REQ  per-channel FIFO can accept.
REQ-008 in_data  input  NUM_REQ x DATA_W  per-channel payload.
REQ-009 req  output  NUM_REQ  request vector to the arbiter.
REQ-010 gnt  input  NUM_REQ  grant vector from the arbiter; combinational from req in the same cycle.
REQ-011 out_valid  output  1  granted transaction available.
REQ-012 out_ready  input  1  downstream accepts the out_* transaction.
REQ-013 out_data  output  DATA_W  payload of the granted transaction.
REQ-014 out_id  output  clog2(NUM_REQ)  channel index of the granted transaction.
REQ-015 gnt_err  output  1  sticky flag for a protocol violation on gnt.

Function
REQ-016 Push to channel i SHALL occur on a cycle where in_valid[i] and in_ready[i] are both high.
REQ-017 in_ready[i] SHALL be high iff the registered occupancy of channel i is below DEPTH; a pop in the same cycle SHALL NOT make in_ready high (no pass-through when full).
REQ-018 Per-channel occupancy counter SHALL be clog2(DEPTH+1) bits wide: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-019 Read and write pointers SHALL be clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-020 slot_free SHALL equal (!out_valid | out_ready).
REQ-021 req[i] SHALL equal (occupancy[i] != 0) & slot_free & !gnt_err; req SHALL be a function of registered state and out_ready only, never of gnt.
REQ-022 A cycle is a win on channel i when req[i] & gnt[i] and gnt is one-hot.
REQ-023 On a win, the block SHALL pop the channel i head and register it: the next cycle shows out_valid=1, out_data=head, out_id=i (latency 1 cycle from gnt).
REQ-024 With no win and out_ready=1, out_valid SHALL clear on the next cycle.
REQ-025 With out_valid=1 and out_ready=0, out_valid, out_data and out_id SHALL hold stable.
REQ-026 When out_valid=1 and out_ready=1 in the same cycle as a new win, the new transaction SHALL replace the old one with no bubble.
REQ-027 gnt bits whose req bit is low SHALL be ignored: no pop, no error.
REQ-028 gnt_err SHALL set on the next edge if popcount(gnt & req) > 1; no pop SHALL occur in that cycle.
REQ-029 gnt_err SHALL stay set until reset and SHALL hold all req low while set; pushes SHALL still be accepted up to full.
REQ-030 Per-channel ordering SHALL be FIFO; there is no ordering guarantee across channels.

Reset
REQ-031 While rst_b=0, all state SHALL clear asynchronously: all counters and pointers 0, out_valid=0, out_data=0, out_id=0, gnt_err=0.
REQ-032 During reset, in_ready SHALL be all ones and req all zeros.
REQ-033 Reset mid-operation SHALL discard all queued and pending transactions; the first push is accepted on the first edge after rst_b rises.

Verification
REQ-034 Push A5 into ch3, gnt=1<<3 while req[3]=1 -> next cycle out_valid=1, out_id=3, out_data=A5; req[3]=0 afterwards.
REQ-035 Push 4 items into ch0 with no gnt -> in_ready[0]=0; a same-cycle push+pop while full -> push rejected, occupancy 3, next push accepted.
REQ-036 out_valid=1, out_ready=0 for 5 cycles -> req all 0, out_* stable; out_ready=1 with gnt=1<<2 -> back-to-back delivery with no bubble.
REQ-037 req=0x006, gnt=0x006 -> gnt_err=1 next cycle, no pop, req stays 0 until rst_b pulse.
REQ-038 Push 6 items into ch1 with pops interleaved -> pointers wrap, and the output order equals the push order.
REQ-039 Assert rst_b=0 mid-transfer with out_valid=1 and 3 items queued -> out_valid=0 immediately, in_ready all ones, req all zeros.

Source files
------------

// File: rtl/lru_req_port.sv
// Per-channel request FIFOs feeding an external arbiter; the one-hot grant
// winner is popped into a single registered output slot with valid/ready.
module lru_req_port #(
  parameter int NUM_REQ = 10,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst_b,
  input  logic [NUM_REQ-1:0]               in_valid,
  output logic [NUM_REQ-1:0]               in_ready,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   in_data,
  output logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               gnt,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_W-1:0]                out_data,
  output logic [ID_W-1:0]                  out_id,
  output logic                             gnt_err
);

  logic [DATA_W-1:0]  mem  [NUM_REQ][DEPTH];
  logic [CNT_W-1:0]   cnt  [NUM_REQ];
  logic [PTR_W-1:0]   wptr [NUM_REQ];
  logic [PTR_W-1:0]   rptr [NUM_REQ];

  logic               slot_free;
  logic [NUM_REQ-1:0] hits;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic               multi;
  logic               win;
  logic [ID_W-1:0]    win_id;

  // Request/grant decode: req never looks at gnt, so the arbiter loop stays acyclic
  always_comb begin
    slot_free = !out_valid | out_ready;
    for (int i = 0; i < NUM_REQ; i++) begin
      in_ready[i] = (cnt[i] < CNT_W'(DEPTH));
      req[i]      = (cnt[i] != '0) & slot_free & !gnt_err;
    end
    hits   = gnt & req;
    multi  = (hits & (hits - NUM_REQ'(1))) != '0;
    win    = (hits != '0) & !multi;
    win_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hits[i]) win_id = ID_W'(i);
    end
    pop  = win ? hits : '0;
    push = in_valid & in_ready;
  end

  // FIFO control state
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt[i]  <= '0;
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + 1'b1;
        if (pop[i])  rptr[i] <= rptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // FIFO storage carries no reset; occupancy alone defines what is valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) mem[i][wptr[i]] <= in_data[i];
    end
  end

  // Output slot: a win always has slot_free, so replacing the old entry is safe
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      gnt_err   <= 1'b0;
    end else begin
      if (win) begin
        out_valid <= 1'b1;
        out_data  <= mem[win_id][rptr[win_id]];
        out_id    <= win_id;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (multi) gnt_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lru_req_port.sv
// Scoreboard bench for lru_req_port: per-channel queue model predicts req,
// in_ready and the delivered (id, data) stream.
module tb_lru_req_port;
  localparam int NR  = 10;
  localparam int W   = 8;
  localparam int D   = 4;
  localparam int IDW = $clog2(NR);

  logic                    clk = 1'b0;
  logic                    rst_b;
  logic [NR-1:0]           in_valid;
  logic [NR-1:0]           in_ready;
  logic [NR-1:0][W-1:0]    in_data;
  logic [NR-1:0]           req;
  logic [NR-1:0]           gnt;
  logic                    out_valid;
  logic                    out_ready;
  logic [W-1:0]            out_data;
  logic [IDW-1:0]          out_id;
  logic                    gnt_err;

  lru_req_port #(.NUM_REQ(NR), .DATA_W(W), .DEPTH(D)) dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .req(req), .gnt(gnt), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .gnt_err(gnt_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0]     mq [NR][$];
  logic             mvalid;
  logic             merr;
  logic [IDW+W-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] model_req(input logic ordy);
    logic [NR-1:0] r;
    for (int i = 0; i < NR; i++)
      r[i] = (mq[i].size() != 0) && (!mvalid || ordy) && !merr;
    return r;
  endfunction

  function automatic logic [NR-1:0] model_inr();
    logic [NR-1:0] r;
    for (int i = 0; i < NR; i++) r[i] = (mq[i].size() < D);
    return r;
  endfunction

  function automatic int model_items();
    int n = 0;
    for (int i = 0; i < NR; i++) n += mq[i].size();
    return n;
  endfunction

  // One clock cycle; entered and left just after a rising edge.
  task automatic step(input logic [NR-1:0] iv, input logic ordy,
                      input bit force_g, input logic [NR-1:0] gval, input int dfix);
    logic [NR-1:0] er, ei, hits, acc;
    logic [W-1:0]  d;
    int            n, w, c, r;
    in_valid  = iv;
    out_ready = ordy;
    for (int i = 0; i < NR; i++)
      in_data[i] = (dfix >= 0) ? W'(dfix) : W'($urandom);
    er = model_req(ordy);
    ei = model_inr();
    #1;
    gnt = '0;
    if (force_g) gnt = gval;
    else begin
      r = $urandom_range(0, 3);
      if (r == 1) gnt[$urandom_range(0, NR-1)] = 1'b1;
      else if (r >= 2 && er != '0) begin
        c = $urandom_range(0, NR-1);
        while (!er[c]) c = (c + 1) % NR;
        gnt[c] = 1'b1;
      end
    end
    @(negedge clk);
    check("req", 64'(req), 64'(er));
    check("in_ready", 64'(in_ready), 64'(ei));
    check("out_valid", 64'(out_valid), 64'(mvalid));
    check("gnt_err", 64'(gnt_err), 64'(merr));
    #1;
    hits = gnt & er;
    n    = $countones(hits);
    w    = -1;
    acc  = iv & ei;
    if (n > 1) merr = 1'b1;
    else if (n == 1)
      for (int i = 0; i < NR; i++) if (hits[i]) w = i;
    if (w >= 0) begin
      d = mq[w].pop_front();
      exp_q.push_back({IDW'(w), d});
      mvalid = 1'b1;
    end else if (ordy) mvalid = 1'b0;
    for (int i = 0; i < NR; i++)
      if (acc[i]) mq[i].push_back(in_data[i]);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst_b    = 1'b0;
    in_valid = '0;
    gnt      = '0;
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_data", 64'(out_data), 64'd0);
    check("rst out_id", 64'(out_id), 64'd0);
    check("rst gnt_err", 64'(gnt_err), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'({NR{1'b1}}));
    check("rst req", 64'(req), 64'd0);
    for (int i = 0; i < NR; i++) mq[i].delete();
    exp_q.delete();
    mvalid = 1'b0;
    merr   = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output must match the oldest predicted delivery
  always @(negedge clk) begin
    logic [IDW+W-1:0] e;
    if (rst_b && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out: got id=%0d data=%0h, expected nothing", out_id, out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_id", 64'(out_id), 64'(e[IDW+W-1:W]));
        check("out_data", 64'(out_data), 64'(e[W-1:0]));
      end
    end
  end

  initial begin
    rst_b = 1'b0; in_valid = '0; in_data = '0; gnt = '0; out_ready = 1'b1;
    mvalid = 1'b0; merr = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // single push to ch3, granted next cycle
    step(NR'(1) << 3, 1'b1, 1'b1, '0, 8'hA5);
    step('0, 1'b1, 1'b1, NR'(1) << 3, -1);
    step('0, 1'b1, 1'b1, '0, -1);

    // fill ch0, then push+pop while full
    for (int k = 0; k < D; k++) step(NR'(1), 1'b1, 1'b1, '0, 16 + k);
    step(NR'(1), 1'b1, 1'b1, NR'(1), 8'h77);
    step(NR'(1), 1'b1, 1'b1, '0, 8'h78);
    step('0, 1'b1, 1'b1, '0, -1);

    // stall the output slot, then back-to-back deliveries from ch2
    for (int k = 0; k < 3; k++) step(NR'(1) << 2, 1'b1, 1'b1, '0, 48 + k);
    step('0, 1'b0, 1'b1, NR'(1), -1);
    for (int k = 0; k < 5; k++) step('0, 1'b0, 1'b0, '0, -1);
    step('0, 1'b1, 1'b1, NR'(1) << 2, -1);
    step('0, 1'b1, 1'b1, NR'(1) << 2, -1);
    step('0, 1'b1, 1'b1, '0, -1);

    // multiple grants: sticky error, req held low
    step(NR'(6), 1'b1, 1'b1, '0, -1);
    step('0, 1'b1, 1'b1, NR'(6), -1);
    for (int k = 0; k < 4; k++) step(NR'($urandom), 1'b1, 1'b1, NR'(6), -1);
    do_reset();

    // pointer wrap on ch1 with interleaved pops
    for (int k = 0; k < 8; k++)
      step((k < 6) ? NR'(2) : NR'(0), 1'b1, 1'b1, (k % 2) ? NR'(2) : NR'(0), 96 + k);
    for (int k = 0; k < 6; k++) step('0, 1'b1, 1'b1, NR'(2), -1);

    // reset mid-transfer with a held output and queued items
    for (int k = 0; k < D; k++) step(NR'(1) << 5, 1'b1, 1'b1, '0, -1);
    step('0, 1'b0, 1'b1, NR'(1) << 5, -1);
    step('0, 1'b0, 1'b0, '0, -1);
    do_reset();

    // randomized traffic
    for (int k = 0; k < 2000; k++)
      step(NR'($urandom) & NR'($urandom), ($urandom_range(0, 3) != 0), 1'b0, '0, -1);
    for (int k = 0; k < 300 && (model_items() != 0 || exp_q.size() != 0); k++)
      step('0, 1'b1, 1'b0, '0, -1);
    check("drain exp_q", 64'(exp_q.size()), 64'd0);
    check("drain model", 64'(model_items()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
